// File: rtl/gf22_sram_sp_8192x64_hd.sv
// Behavioural single-port 8192x64 SRAM with per-bit write mask and registered read data.
// Reset clears only the output register; the array keeps its contents across reset.
module gf22_sram_sp_8192x64_hd #(
  parameter int WORDS = 8192,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE0,
  input  logic [AW-1:0]    A0,
  input  logic [WIDTH-1:0] D0,
  input  logic             WE0,
  input  logic [WIDTH-1:0] WEM0,
  output logic [WIDTH-1:0] Q0
);

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [WIDTH-1:0] q0_q;
  logic [WIDTH-1:0] q0_d;
  logic             wr_en;
  logic             rd_en;

  // Reset wins over any access request, so a write coinciding with reset is dropped.
  assign wr_en = !RST && CE0 && WE0;
  assign rd_en = CE0 && !WE0;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[A0] <= (mem_q[A0] & ~WEM0) | (D0 & WEM0);
    end
  end

  always_comb begin
    q0_d = q0_q;
    if (rd_en) begin
      q0_d = mem_q[A0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q0_q <= '0;
    end else begin
      q0_q <= q0_d;
    end
  end

  assign Q0 = q0_q;

endmodule

// File: tb/tb_gf22_sram_sp_8192x64_hd.sv
// Self-checking bench for gf22_sram_sp_8192x64_hd: directed scenarios plus a randomized
// masked read/write regression against a word-level array model.
module tb_gf22_sram_sp_8192x64_hd;

  logic        CLK;
  logic        RST;
  logic        CE0;
  logic [12:0] A0;
  logic [63:0] D0;
  logic        WE0;
  logic [63:0] WEM0;
  logic [63:0] Q0;

  int errors;
  int checks;

  logic [63:0] model [8192];
  logic [63:0] expQ;
  int          pool [32];

  gf22_sram_sp_8192x64_hd dut (
    .CLK  (CLK),
    .RST  (RST),
    .CE0  (CE0),
    .A0   (A0),
    .D0   (D0),
    .WE0  (WE0),
    .WEM0 (WEM0),
    .Q0   (Q0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the edge and outputs are sampled there too.
  task automatic cycle(input logic rst, input logic ce, input logic we,
                       input logic [12:0] a, input logic [63:0] d, input logic [63:0] m);
    RST  = rst;
    CE0  = ce;
    WE0  = we;
    A0   = a;
    D0   = d;
    WEM0 = m;
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    CE0  = 1'b0;
  endtask

  task automatic doWrite(input logic [12:0] a, input logic [63:0] d, input logic [63:0] m);
    cycle(1'b0, 1'b1, 1'b1, a, d, m);
    model[a] = (model[a] & ~m) | (d & m);
  endtask

  task automatic doRead(input logic [12:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, {$urandom, $urandom}, {$urandom, $urandom});
    expQ = model[a];
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 13'h0123, 64'h0, 64'h0);
    expQ = 64'h0;
    checks++;
    if (Q0 !== expQ) begin
      errors++;
      $display("[TB] FAIL reset_q0 got=%h exp=%h", Q0, expQ);
    end
  endtask

  task automatic test_full_rw();
    doWrite(13'h0000, 64'hDEADBEEF_01234567, '1);
    doWrite(13'h1FFF, 64'hA5A5A5A5_A5A5A5A5, '1);
    checks++;
    if (Q0 !== expQ) begin
      errors++;
      $display("[TB] FAIL write_no_writethrough got=%h exp=%h", Q0, expQ);
    end
    doRead(13'h0000);
    checks++;
    if (Q0 !== 64'hDEADBEEF_01234567) begin
      errors++;
      $display("[TB] FAIL read_addr0 got=%h exp=%h", Q0, 64'hDEADBEEF_01234567);
    end
    doRead(13'h1FFF);
    checks++;
    if (Q0 !== 64'hA5A5A5A5_A5A5A5A5) begin
      errors++;
      $display("[TB] FAIL read_addr1fff got=%h exp=%h", Q0, 64'hA5A5A5A5_A5A5A5A5);
    end
  endtask

  task automatic test_mask();
    doWrite(13'd5, 64'h0, '1);
    doWrite(13'd5, '1, 64'h00000000_FFFF0000);
    doRead(13'd5);
    checks++;
    if (Q0 !== 64'h00000000_FFFF0000) begin
      errors++;
      $display("[TB] FAIL mask_partial got=%h exp=%h", Q0, 64'h00000000_FFFF0000);
    end
    doWrite(13'd5, 64'h12345678_9ABCDEF0, 64'h0);
    doRead(13'd5);
    checks++;
    if (Q0 !== 64'h00000000_FFFF0000) begin
      errors++;
      $display("[TB] FAIL mask_zero got=%h exp=%h", Q0, 64'h00000000_FFFF0000);
    end
  endtask

  task automatic test_hold();
    logic [63:0] held;
    doWrite(13'd6, 64'h0F0F0F0F_F0F0F0F0, '1);
    doRead(13'd5);
    held = model[5];
    for (int i = 0; i < 10; i++) begin
      // Idle cycles with junk on the other inputs, including WE0, must change nothing.
      cycle(1'b0, 1'b0, 1'($urandom), 13'd6, {$urandom, $urandom}, '1);
      checks++;
      if (Q0 !== held) begin
        errors++;
        $display("[TB] FAIL hold_idle cyc=%0d got=%h exp=%h", i, Q0, held);
      end
    end
    doWrite(13'd6, 64'hCAFEF00D_8BADF00D, 64'hFFFFFFFF_00000000);
    checks++;
    if (Q0 !== held) begin
      errors++;
      $display("[TB] FAIL hold_after_write got=%h exp=%h", Q0, held);
    end
    doRead(13'd6);
    checks++;
    if (Q0 !== 64'hCAFEF00D_F0F0F0F0) begin
      errors++;
      $display("[TB] FAIL hold_addr6 got=%h exp=%h", Q0, 64'hCAFEF00D_F0F0F0F0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 64; n++) begin
      doWrite(13'(n), 64'(n * 3), '1);
      doRead(13'(n));
      checks++;
      if (Q0 !== 64'(n * 3)) begin
        errors++;
        $display("[TB] FAIL b2b n=%0d got=%h exp=%h", n, Q0, 64'(n * 3));
      end
    end
  endtask

  task automatic test_random();
    int          op;
    int          idx;
    logic [12:0] a;
    logic [63:0] d;
    logic [63:0] m;
    for (int i = 0; i < 32; i++) begin
      pool[i] = int'($urandom_range(64, 8191));
      doWrite(13'(pool[i]), {$urandom, $urandom}, '1);
    end
    for (int i = 0; i < 400; i++) begin
      idx = int'($urandom_range(0, 31));
      a   = 13'(pool[idx]);
      d   = {$urandom, $urandom};
      m   = {$urandom, $urandom};
      op  = int'($urandom_range(0, 2));
      if (op == 0) begin
        doWrite(a, d, m);
      end else if (op == 1) begin
        doRead(a);
      end else begin
        cycle(1'b0, 1'b0, 1'($urandom), a, d, m);
      end
      checks++;
      if (Q0 !== expQ) begin
        errors++;
        $display("[TB] FAIL random i=%0d op=%0d addr=%h got=%h exp=%h", i, op, a, Q0, expQ);
      end
    end
  endtask

  task automatic test_reset_midstream();
    doWrite(13'd7, 64'h7777_0000_BEEF_1234, '1);
    doRead(13'd7);
    cycle(1'b1, 1'b1, 1'b1, 13'd7, 64'h1, '1);
    checks++;
    if (Q0 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL midreset_q0 got=%h exp=%h", Q0, 64'h0);
    end
    doRead(13'd7);
    checks++;
    if (Q0 !== 64'h7777_0000_BEEF_1234) begin
      errors++;
      $display("[TB] FAIL midreset_array got=%h exp=%h", Q0, 64'h7777_0000_BEEF_1234);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    expQ   = 64'h0;
    RST    = 1'b0;
    CE0    = 1'b0;
    WE0    = 1'b0;
    A0     = 13'h0;
    D0     = 64'h0;
    WEM0   = 64'h0;
    for (int i = 0; i < 8192; i++) model[i] = 64'hx;
    @(posedge CLK);
    #1;
    test_reset();
    test_full_rw();
    test_mask();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
